// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, FSM state encoding and the DIV sanitising helper.
package mmio_uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;

    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 4;
    localparam int STAT_COUNT_MSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // A divider of zero would never end a bit, so it is stored as one.
    function automatic logic [15:0] fix_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Generic synchronous FIFO with occupancy count; the head entry is readable
// without latency so a consumer can pop and use it on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A simultaneous pop frees a slot, so a push into a full FIFO is accepted then.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register window decode, TX FIFO,
// programmable baud counter and the frame FSM driving a registered tx_o.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        hit_o,
    output logic        tx_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          w_hit;
    logic [1:0]    w_off;
    logic          w_wr;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [31:0]   w_status;
    logic          w_bit_end;
    logic          w_unused;

    uart_state_e   r_state;
    uart_state_e   w_state_next;
    logic [15:0]   r_div;
    logic [15:0]   r_baud;
    logic [15:0]   w_baud_next;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_next;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_next;
    logic          r_ovf;
    logic          r_tx;
    logic          w_tx_next;

    assign w_hit  = ce && (addr[31:4] == BASE_ADDR[31:4]);
    assign w_off  = addr[3:2];
    assign w_wr   = w_hit && we;
    assign w_push = w_wr && (w_off == REG_TXDATA);
    assign hit_o  = w_hit;
    assign tx_o   = r_tx;

    assign w_unused = &{1'b0, addr[1:0], data_i[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (data_i[7:0]),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_comb begin
        w_status = '0;
        w_status[STAT_FULL]  = w_full;
        w_status[STAT_EMPTY] = w_empty;
        w_status[STAT_BUSY]  = (r_state != ST_IDLE);
        w_status[STAT_OVF]   = r_ovf;
        w_status[STAT_COUNT_MSB:STAT_COUNT_LSB] = 5'(w_count);
    end

    always_comb begin
        data_o = '0;
        if (w_hit && !we) begin
            case (w_off)
                REG_STATUS: data_o = w_status;
                REG_DIV:    data_o = {16'd0, r_div};
                default:    data_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= DEFAULT_DIV;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr && (w_off == REG_DIV)) begin
                r_div <= fix_div(data_i[15:0]);
            end
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_wr && (w_off == REG_STATUS) && data_i[STAT_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Compared against the live divider; >= ends a bit at once if DIV shrank below the count.
    assign w_bit_end = (r_baud >= (r_div - 16'd1));

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;

        if (r_state != ST_IDLE) begin
            w_baud_next = w_bit_end ? 16'd0 : (r_baud + 16'd1);
        end

        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_baud_next  = 16'd0;
                    w_bit_next   = 3'd0;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_bit_next   = 3'd0;
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_bit_next   = 3'd0;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The line level is derived from the next state so tx_o is a clean flop output.
    always_comb begin
        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[0];
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

endmodule
